// File: rtl/median_bus_pkg.sv
// Shared definitions for the Avalon-MM median-filter master.
// Holds the FSM state encoding, default tap count and sample width, and the
// word addresses of the median-filter register slave (five tap registers
// at 0..4; the result is read back from address 0).
package median_bus_pkg;

  localparam int NUM_TAPS = 5;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int BUS_W    = 32;

  localparam logic [ADDR_W-1:0] ADDR_TAP0   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_TAP1   = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_TAP2   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_TAP3   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_TAP4   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_RESULT = 3'd0;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_WRITE,
    ST_SETTLE,
    ST_READ,
    ST_CAPTURE
  } state_t;

endpackage

// File: rtl/avalon_median_master_if.sv
// Bundle of the sample stream, result strobe and Avalon-MM bus signals used by
// avalon_median_master.
//   sample / sample_valid / sample_ready : producer stream (valid/ready)
//   result / result_valid / busy         : median result, one-cycle strobe, busy flag
//   chip_select_n / write_n / read_n     : Avalon strobes, active-low
//   address / wdata / rdata              : Avalon word address, write data, read data
// Modport master is the initiator block; modport slave is its environment
// (producer, consumer and the median-filter register slave).
interface avalon_median_master_if #(
  parameter int DATA_W = median_bus_pkg::DATA_W
);
  import median_bus_pkg::*;

  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              sample_ready;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              busy;
  logic              chip_select_n;
  logic              write_n;
  logic              read_n;
  logic [ADDR_W-1:0] address;
  logic [BUS_W-1:0]  wdata;
  logic [BUS_W-1:0]  rdata;

  modport master (
    input  sample, sample_valid, rdata,
    output sample_ready, result, result_valid, busy,
           chip_select_n, write_n, read_n, address, wdata
  );

  modport slave (
    output sample, sample_valid, rdata,
    input  sample_ready, result, result_valid, busy,
           chip_select_n, write_n, read_n, address, wdata
  );

endinterface

// File: rtl/avalon_median_master.sv
// Avalon-MM initiator for the median-filter register slave.
// Collects NUM_TAPS samples from a valid/ready stream, writes them to tap
// addresses 0..NUM_TAPS-1 (one write per cycle), waits SETTLE idle cycles for
// the filter to compute, reads the median from address 0 and, READ_LAT cycles
// after the read, presents it on result with a one-cycle result_valid pulse.
// Ports:
//   iClk   : clock, everything on the rising edge
//   iReset : synchronous active-high reset
//   bus    : avalon_median_master_if.master (stream, result and Avalon signals)
// All Avalon outputs, result, result_valid and busy are registered; they are
// loaded from the next-state decode so each strobe appears in the cycle that
// follows the edge that enters the corresponding state.
module avalon_median_master #(
  parameter int NUM_TAPS = median_bus_pkg::NUM_TAPS,
  parameter int DATA_W   = median_bus_pkg::DATA_W,
  parameter int SETTLE   = 2,
  parameter int READ_LAT = 1
) (
  input logic                    iClk,
  input logic                    iReset,
  avalon_median_master_if.master bus
);
  import median_bus_pkg::*;

  localparam int IDX_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int WAIT_MAX = (SETTLE > READ_LAT) ? SETTLE : READ_LAT;
  localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [IDX_W-1:0]  LAST_TAP    = IDX_W'(NUM_TAPS - 1);
  localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [WAIT_W-1:0] CAPT_LAST   = WAIT_W'((READ_LAT > 0) ? READ_LAT - 1 : 0);

  function automatic logic [BUS_W-1:0] to_word(input logic [DATA_W-1:0] s);
    return BUS_W'(s);
  endfunction

  state_t            state, state_next;
  logic [IDX_W-1:0]  cnt, cnt_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic [DATA_W-1:0] tap_buf [NUM_TAPS];
  logic              accept;
  logic              capture;

  logic              cs_n_next, wr_n_next, rd_n_next;
  logic [ADDR_W-1:0] addr_next;
  logic [BUS_W-1:0]  wdata_next;
  logic [DATA_W-1:0] wr_sample;

  // Only the low DATA_W bits of the read word carry the median.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^bus.rdata[BUS_W-1:DATA_W];

  assign bus.sample_ready = (state == ST_COLLECT);
  assign accept           = bus.sample_valid & bus.sample_ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    wait_next  = wait_cnt;
    capture    = 1'b0;
    case (state)
      ST_COLLECT: begin
        if (accept) begin
          if (cnt == LAST_TAP) begin
            state_next = ST_WRITE;
            cnt_next   = '0;
            idx_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (idx == LAST_TAP) begin
          idx_next   = '0;
          wait_next  = '0;
          state_next = (SETTLE > 0) ? ST_SETTLE : ST_READ;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (wait_cnt == SETTLE_LAST) begin
          wait_next  = '0;
          state_next = ST_READ;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end
      ST_READ: begin
        wait_next  = '0;
        state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // The slave's read data is valid READ_LAT edges after the read edge.
        if (wait_cnt == CAPT_LAST) begin
          capture    = 1'b1;
          wait_next  = '0;
          state_next = ST_COLLECT;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_next = ST_COLLECT;
        cnt_next   = '0;
        idx_next   = '0;
        wait_next  = '0;
      end
    endcase
  end

  always_comb begin
    cs_n_next  = 1'b1;
    wr_n_next  = 1'b1;
    rd_n_next  = 1'b1;
    addr_next  = '0;
    wdata_next = '0;
    // With a single tap the first write's sample is still on the stream input
    // (it lands in tap_buf on this same edge), so forward it directly.
    wr_sample = tap_buf[idx_next];
    if (accept && (cnt == idx_next)) begin
      wr_sample = bus.sample;
    end
    case (state_next)
      ST_WRITE: begin
        cs_n_next  = 1'b0;
        wr_n_next  = 1'b0;
        addr_next  = ADDR_TAP0 + ADDR_W'(idx_next);
        wdata_next = to_word(wr_sample);
      end
      ST_READ: begin
        cs_n_next = 1'b0;
        rd_n_next = 1'b0;
        addr_next = ADDR_RESULT;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state             <= ST_COLLECT;
      cnt               <= '0;
      idx               <= '0;
      wait_cnt          <= '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        tap_buf[i] <= '0;
      end
      bus.chip_select_n <= 1'b1;
      bus.write_n       <= 1'b1;
      bus.read_n        <= 1'b1;
      bus.address       <= '0;
      bus.wdata         <= '0;
      bus.result        <= '0;
      bus.result_valid  <= 1'b0;
      bus.busy          <= 1'b0;
    end else begin
      state             <= state_next;
      cnt               <= cnt_next;
      idx               <= idx_next;
      wait_cnt          <= wait_next;
      if (accept) begin
        tap_buf[cnt] <= bus.sample;
      end
      bus.chip_select_n <= cs_n_next;
      bus.write_n       <= wr_n_next;
      bus.read_n        <= rd_n_next;
      bus.address       <= addr_next;
      bus.wdata         <= wdata_next;
      if (capture) begin
        bus.result <= bus.rdata[DATA_W-1:0];
      end
      bus.result_valid  <= capture;
      bus.busy          <= (state_next != ST_COLLECT);
    end
  end

endmodule

// File: tb/tb_avalon_median_master.sv
// Directed bench for avalon_median_master: two instances (SETTLE=2 and
// SETTLE=0) each attached to a behavioural median-filter register slave.
module tb_avalon_median_master;
  import median_bus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  avalon_median_master_if #(.DATA_W(8)) b0 ();
  avalon_median_master_if #(.DATA_W(8)) b1 ();

  avalon_median_master #(.NUM_TAPS(5), .DATA_W(8), .SETTLE(2), .READ_LAT(1)) dut0 (
    .iClk(clk), .iReset(rst), .bus(b0)
  );
  avalon_median_master #(.NUM_TAPS(5), .DATA_W(8), .SETTLE(0), .READ_LAT(1)) dut1 (
    .iClk(clk), .iReset(rst), .bus(b1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- median-filter slave models ----------------
  logic [7:0]  regs0 [5];
  logic [7:0]  regs1 [5];
  logic        ovr_en;
  logic [31:0] ovr_val;

  function automatic logic [7:0] med5(input logic [7:0] r [5]);
    logic [7:0] m;
    int lt, le;
    m = r[0];
    for (int i = 0; i < 5; i++) begin
      lt = 0;
      le = 0;
      for (int j = 0; j < 5; j++) begin
        if (r[j] < r[i])  lt++;
        if (r[j] <= r[i]) le++;
      end
      if (lt <= 2 && le >= 3) m = r[i];
    end
    return m;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) regs0[i] <= 8'd0;
      b0.rdata <= 32'd0;
    end else begin
      if (!b0.chip_select_n && !b0.write_n && b0.address < 3'd5) regs0[b0.address] <= b0.wdata[7:0];
      if (!b0.chip_select_n && !b0.read_n) b0.rdata <= ovr_en ? ovr_val : {24'd0, med5(regs0)};
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) regs1[i] <= 8'd0;
      b1.rdata <= 32'd0;
    end else begin
      if (!b1.chip_select_n && !b1.write_n && b1.address < 3'd5) regs1[b1.address] <= b1.wdata[7:0];
      if (!b1.chip_select_n && !b1.read_n) b1.rdata <= {24'd0, med5(regs1)};
    end
  end

  // ---------------- monitors (sampled mid-cycle) ----------------
  int          acc_e0[$], wr_c0[$], wr_a0[$], rd_c0[$], rd_a0[$], res_c0[$], res_v0[$];
  logic [31:0] wr_d0[$];
  int          acc_e1[$], wr_c1[$], rd_c1[$], res_c1[$], res_v1[$];
  logic [31:0] wr_d1[$];
  bit          prot0 = 1'b0;
  bit          prot1 = 1'b0;

  always @(negedge clk) begin
    if (!rst && b0.sample_valid && b0.sample_ready) acc_e0.push_back(cyc + 1);
    if (!b0.chip_select_n && !b0.write_n) begin
      wr_c0.push_back(cyc);
      wr_a0.push_back(int'(b0.address));
      wr_d0.push_back(b0.wdata);
    end
    if (!b0.chip_select_n && !b0.read_n) begin
      rd_c0.push_back(cyc);
      rd_a0.push_back(int'(b0.address));
    end
    if (b0.result_valid) begin
      res_c0.push_back(cyc);
      res_v0.push_back(int'(b0.result));
    end
    if ((!b0.write_n && !b0.read_n) || (b0.chip_select_n && (!b0.write_n || !b0.read_n)))
      prot0 = 1'b1;
  end

  always @(negedge clk) begin
    if (!rst && b1.sample_valid && b1.sample_ready) acc_e1.push_back(cyc + 1);
    if (!b1.chip_select_n && !b1.write_n) begin
      wr_c1.push_back(cyc);
      wr_d1.push_back(b1.wdata);
    end
    if (!b1.chip_select_n && !b1.read_n) rd_c1.push_back(cyc);
    if (b1.result_valid) begin
      res_c1.push_back(cyc);
      res_v1.push_back(int'(b1.result));
    end
    if ((!b1.write_n && !b1.read_n) || (b1.chip_select_n && (!b1.write_n || !b1.read_n)))
      prot1 = 1'b1;
  end

  // Queue offsets marking the start of the current step.
  int ab0, wb0, rb0, sb0, ab1, wb1, rb1, sb1;

  task automatic mark();
    ab0 = acc_e0.size(); wb0 = wr_c0.size(); rb0 = rd_c0.size(); sb0 = res_c0.size();
    ab1 = acc_e1.size(); wb1 = wr_c1.size(); rb1 = rd_c1.size(); sb1 = res_c1.size();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer five samples to dut0; gap idle cycles follow each accepted sample.
  task automatic feed0(input logic [7:0] w [5], input int gap);
    int  sent, budget;
    logic rdy;
    sent = 0;
    budget = 200;
    while (sent < 5 && budget > 0) begin
      b0.sample       = w[sent];
      b0.sample_valid = 1'b1;
      rdy = b0.sample_ready;
      tick();
      budget--;
      if (rdy) begin
        sent++;
        if (gap > 0) begin
          b0.sample_valid = 1'b0;
          repeat (gap) tick();
        end
      end
    end
    b0.sample_valid = 1'b0;
  endtask

  task automatic wait_res0(input int n);
    int budget;
    budget = 80;
    while ((res_c0.size() - sb0) < n && budget > 0) begin
      tick();
      budget--;
    end
    repeat (3) tick();
  endtask

  initial begin
    logic [7:0]  w [5];
    logic [7:0]  w10 [10];
    logic [31:0] expd [5];
    int e0, sent, stall, budget;
    logic rdy;

    rst = 1'b1;
    ovr_en = 1'b0;
    ovr_val = 32'd0;
    b0.sample = 8'd0; b0.sample_valid = 1'b1;   // offered during reset, must be dropped
    b1.sample = 8'd0; b1.sample_valid = 1'b0;
    repeat (3) tick();
    check("rst_cs_n",   32'(b0.chip_select_n), 32'd1);
    check("rst_wr_n",   32'(b0.write_n), 32'd1);
    check("rst_rd_n",   32'(b0.read_n), 32'd1);
    check("rst_addr",   32'(b0.address), 32'd0);
    check("rst_wdata",  b0.wdata, 32'd0);
    check("rst_result", 32'(b0.result), 32'd0);
    check("rst_rvalid", 32'(b0.result_valid), 32'd0);
    check("rst_busy",   32'(b0.busy), 32'd0);
    check("rst_busy1",  32'(b1.busy), 32'd0);
    b0.sample_valid = 1'b0;
    rst = 1'b0;
    check("rst_ready",  32'(b0.sample_ready), 32'd1);
    tick();

    // ---- basic window 10,50,30,20,40 -> 30 ----
    mark();
    w = '{8'd10, 8'd50, 8'd30, 8'd20, 8'd40};
    expd = '{32'h0A, 32'h32, 32'h1E, 32'h14, 32'h28};
    feed0(w, 0);
    check("A_ready_busy", {30'd0, b0.sample_ready, b0.busy}, 32'd1);
    wait_res0(1);
    e0 = acc_e0[ab0 + 4];
    check("A_nacc", acc_e0.size() - ab0, 5);
    check("A_nwr", wr_c0.size() - wb0, 5);
    for (int i = 0; i < 5; i++) begin
      check("A_wr_addr", wr_a0[wb0 + i], i);
      check("A_wr_data", wr_d0[wb0 + i], expd[i]);
      check("A_wr_cyc", wr_c0[wb0 + i], e0 + i);
    end
    check("A_nrd", rd_c0.size() - rb0, 1);
    check("A_rd_addr", rd_a0[rb0], 0);
    check("A_rd_cyc", rd_c0[rb0], e0 + 7);
    check("A_nres", res_c0.size() - sb0, 1);
    check("A_res_cyc", res_c0[sb0], e0 + 9);
    check("A_res_val", res_v0[sb0], 30);
    check("A_hold_val", 32'(b0.result), 32'd30);
    check("A_hold_vld", 32'(b0.result_valid), 32'd0);

    // ---- valid held high for 10 samples: 90,10,70,30,50 -> 50; 5,200,100,150,60 -> 100 ----
    mark();
    w10 = '{8'd90, 8'd10, 8'd70, 8'd30, 8'd50, 8'd5, 8'd200, 8'd100, 8'd150, 8'd60};
    sent = 0; stall = 0; budget = 200;
    while (sent < 10 && budget > 0) begin
      b0.sample = w10[sent];
      b0.sample_valid = 1'b1;
      rdy = b0.sample_ready;
      if (!rdy) stall++;
      tick();
      budget--;
      if (rdy) sent++;
    end
    b0.sample_valid = 1'b0;
    wait_res0(2);
    check("B_nacc", acc_e0.size() - ab0, 10);
    check("B_stall", stall, 9);
    check("B_period", acc_e0[ab0 + 9] - acc_e0[ab0 + 4], 14);
    check("B_nres", res_c0.size() - sb0, 2);
    check("B_res0", res_v0[sb0], 50);
    check("B_res1", res_v0[sb0 + 1], 100);
    check("B_res0_cyc", res_c0[sb0], acc_e0[ab0 + 4] + 9);
    check("B_res1_cyc", res_c0[sb0 + 1], acc_e0[ab0 + 9] + 9);
    check("B_nwr", wr_c0.size() - wb0, 10);
    check("B_wr5", wr_d0[wb0 + 5], 32'h05);
    check("B_wr9", wr_d0[wb0 + 9], 32'h3C);

    // ---- reset during write idx=2, then reset during partial collect ----
    mark();
    w = '{8'd200, 8'd201, 8'd202, 8'd203, 8'd204};
    feed0(w, 0);
    tick();
    tick();
    check("C_idx2_addr", 32'(b0.address), 32'd2);
    check("C_idx2_wr_n", 32'(b0.write_n), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("C_strobes", {29'd0, b0.chip_select_n, b0.write_n, b0.read_n}, 32'd7);
    check("C_busy", 32'(b0.busy), 32'd0);
    check("C_ready", 32'(b0.sample_ready), 32'd1);
    repeat (15) tick();
    check("C_no_result", res_c0.size() - sb0, 0);
    b0.sample = 8'd0;
    b0.sample_valid = 1'b1;
    tick();
    tick();
    b0.sample_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    feed0(w, 0);
    wait_res0(1);
    check("C_nres", res_c0.size() - sb0, 1);
    check("C_res_val", res_v0[sb0], 3);

    // ---- upper read-data bits ignored ----
    mark();
    ovr_en = 1'b1;
    ovr_val = 32'hFFFF_FF1E;
    w = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
    feed0(w, 0);
    wait_res0(1);
    ovr_en = 1'b0;
    check("D_res_val", res_v0[sb0], 32'h1E);

    // ---- SETTLE=0 instance: 9,3,6,1,8 -> 6 ----
    mark();
    w = '{8'd9, 8'd3, 8'd6, 8'd1, 8'd8};
    for (int i = 0; i < 5; i++) begin
      b1.sample = w[i];
      b1.sample_valid = 1'b1;
      tick();
    end
    b1.sample_valid = 1'b0;
    budget = 80;
    while ((res_c1.size() - sb1) < 1 && budget > 0) begin
      tick();
      budget--;
    end
    repeat (3) tick();
    e0 = acc_e1[ab1 + 4];
    check("E_nacc", acc_e1.size() - ab1, 5);
    check("E_last_wr_cyc", wr_c1[wb1 + 4], e0 + 4);
    check("E_last_wr_data", wr_d1[wb1 + 4], 32'h08);
    check("E_rd_cyc", rd_c1[rb1], e0 + 5);
    check("E_res_cyc", res_c1[sb1], e0 + 7);
    check("E_res_val", res_v1[sb1], 6);

    // ---- sparse valid, one sample every 3 cycles: 60,20,80,40,100 -> 60 ----
    mark();
    w = '{8'd60, 8'd20, 8'd80, 8'd40, 8'd100};
    expd = '{32'h3C, 32'h14, 32'h50, 32'h28, 32'h64};
    feed0(w, 2);
    wait_res0(1);
    e0 = acc_e0[ab0 + 4];
    check("F_span", e0 - acc_e0[ab0], 12);
    check("F_first_wr", wr_c0[wb0], e0);
    for (int i = 0; i < 5; i++) check("F_wr_data", wr_d0[wb0 + i], expd[i]);
    check("F_res_val", res_v0[sb0], 60);

    check("protocol0", 32'(prot0), 32'd0);
    check("protocol1", 32'(prot1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
